sdram_mem_tester: RTL and testbench
===================================

Name: sdram_mem_tester

Overview:
- Self-checking memory test engine that drives the SDRAM controller's processor-side request interface (addr/data/we/re/ack/busy).
- On start it runs two phases over [START_ADDR..END_ADDR]:
  - write phase: writes a deterministic pattern to every word;
  - read phase: reads every word back and compares it with the pattern.
- Reports pass/fail, an error count, first-failure details and a timeout flag to the board top level for LED/HEX display.

Parameters:
- ADDR_WIDTH, 25, request address width (matches controller addr_i).
- DATA_WIDTH, 16, SDRAM word width.
- START_ADDR, 0, first word address tested.
- END_ADDR, 1023, last word address tested; must be >= START_ADDR (elaboration-time check).
- TIMEOUT_CYCLES, 4096, maximum sys_clk cycles waiting for ack_i per request.
- SEED, 16'hA5A5, pattern seed; must be nonzero.

Ports:
- sys_clk  in  1  system clock (SDRAM controller clock domain)
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse: clear results and begin test
- abort_i  in  1  one-cycle pulse: stop test, return to IDLE
- addr_o  out  ADDR_WIDTH  request address to controller
- wdata_o  out  DATA_WIDTH  write data to controller
- we_o  out  1  write request pulse
- re_o  out  1  read request pulse
- rdata_i  in  DATA_WIDTH  read data from controller, valid with ack_i
- ack_i  in  1  request completion pulse
- busy_i  in  1  controller cannot accept a request
- running_o  out  1  test in progress
- done_o  out  1  test finished (level, held until next start)
- pass_o  out  1  valid when done_o: no mismatches and no timeout
- timeout_o  out  1  an ack did not arrive within TIMEOUT_CYCLES
- err_count_o  out  16  mismatch count, saturating at 16'hFFFF
- first_err_addr_o  out  ADDR_WIDTH  address of first mismatch
- first_err_data_o  out  DATA_WIDTH  data read at first mismatch

Behaviour:
- Reset: all outputs 0; state IDLE; pattern state = SEED.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- IDLE:
  - on start_i: clear err_count_o, first_err_*, timeout_o, pass_o, done_o;
  - cur_addr = START_ADDR; pattern = SEED; running_o = 1; go to WR_REQ.
- WR_REQ:
  - when !busy_i: register addr_o = cur_addr, wdata_o = pattern(cur_addr), we_o = 1 for exactly one cycle; go to WR_WAIT.
  - while busy_i, wait with no request issued.
- WR_WAIT:
  - we_o = 0; addr_o and wdata_o held stable until ack_i.
  - on ack_i: advance the pattern.
    - If cur_addr == END_ADDR: cur_addr = START_ADDR, pattern = SEED, go to RD_REQ.
    - Otherwise cur_addr++ and return to WR_REQ.
- RD_REQ: as WR_REQ, but with re_o.
- RD_WAIT:
  - on ack_i, compare rdata_i with the expected pattern.
  - On mismatch: err_count_o++ (saturating). If this is the first mismatch (err_count_o == 0 beforehand), capture first_err_addr_o = cur_addr and first_err_data_o = rdata_i.
  - If cur_addr == END_ADDR, go to DONE; otherwise cur_addr++ and return to RD_REQ.
- Timeout:
  - a wait counter resets on entry to each WAIT state and counts while waiting.
  - When it reaches TIMEOUT_CYCLES with no ack: timeout_o = 1, go to DONE.
- DONE:
  - running_o = 0; done_o = 1; pass_o = (err_count == 0 && !timeout_o).
  - All results are held. start_i restarts the test.
- Request latency: at most one request per ack; we_o/re_o assert the cycle after the REQ state first sees !busy_i. ack_i outside WAIT states is ignored.
- Simultaneous events:
  - start_i while running is ignored.
  - abort_i has priority over ack_i/timeout: go to IDLE, drop running_o, leave done_o = 0, no further requests. Results are left as partially accumulated.
  - abort_i and start_i together in IDLE: abort wins, so no start.
- Single-word range (START_ADDR == END_ADDR): exactly one write and one read.
- Reset mid-operation: immediate return to IDLE with reset values. Any request in flight at the controller is abandoned.

Optional Feature:
- Macro MEMTEST_LFSR_PATTERN_EN.
- Defined:
  - pattern is a 16-bit Fibonacci LFSR (taps x^16+x^14+x^13+x^11+1), loaded with SEED at the start of each phase;
  - it advances one step per acknowledged word, so the read phase replays the write sequence.
- Undefined: pattern(a) = a[15:0] ^ SEED; no LFSR logic is present.

Test Plan:
- Clean pass: ideal memory model (ack 3 cycles after request, busy_i = 0), range 0..15, start pulse -> exactly 16 we_o pulses then 16 re_o pulses; done_o = 1, pass_o = 1, err_count_o = 0.
- Corruption: model returns 16'h0000 at address 5, range 0..15 -> err_count_o = 1, first_err_addr_o = 5, first_err_data_o = 16'h0000, pass_o = 0.
- Busy backpressure: busy_i held high for 20 cycles at addresses 0 and 7 -> no we_o/re_o while busy; addr_o/wdata_o stable until ack; final result pass.
- Timeout: model never acks the read at address 3, TIMEOUT_CYCLES = 64 -> timeout_o = 1 after 64 wait cycles, done_o = 1, pass_o = 0, no further requests.
- Abort: abort_i pulsed during the write phase at address 8 -> running_o = 0, done_o = 0, state IDLE; a later start_i runs the full test to pass.
- Pattern check: without macro, write data at address 2 = 16'hA5A7. With MEMTEST_LFSR_PATTERN_EN, first write = 16'hA5A5 and subsequent writes follow the LFSR sequence; read-back compares pass.

Source files
------------

// File: rtl/sdram_mem_tester.sv
`default_nettype none
// ============================================================================
// Module   : sdram_mem_tester
// Brief    : Self-checking memory test engine for the SDRAM controller's
//            processor-side request port. Writes a deterministic pattern to
//            every word of [START_ADDR..END_ADDR], reads it all back, and
//            reports pass/fail, error count, first failure and timeout.
// Options  : MEMTEST_LFSR_PATTERN_EN - when defined, the pattern is a 16-bit
//            Fibonacci LFSR (x^16+x^14+x^13+x^11+1) seeded with SEED per
//            phase; otherwise pattern(a) = a[15:0] ^ SEED.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_mem_tester #(
    parameter int unsigned ADDR_WIDTH     = 25,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned START_ADDR     = 0,
    parameter int unsigned END_ADDR       = 1023,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [15:0] SEED           = 16'hA5A5
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  we_o,
    output logic                  re_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  ack_i,
    input  logic                  busy_i,
    output logic                  running_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [DATA_WIDTH-1:0] first_err_data_o
);

    localparam logic [ADDR_WIDTH-1:0] c_start_addr = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_end_addr   = ADDR_WIDTH'(END_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one   = ADDR_WIDTH'(1);
    localparam int unsigned           c_cnt_w      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_last   = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one    = c_cnt_w'(1);

    // Elaboration-time parameter sanity checks
    generate
        if (END_ADDR < START_ADDR) begin : g_bad_range
            $error("sdram_mem_tester: END_ADDR must be >= START_ADDR");
        end
        if (SEED == 16'h0000) begin : g_bad_seed
            $error("sdram_mem_tester: SEED must be nonzero");
        end
        if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
            $error("sdram_mem_tester: TIMEOUT_CYCLES must be nonzero");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [c_cnt_w-1:0]      r_wait_cnt;
    logic [15:0]             w_pattern16;
    logic [DATA_WIDTH-1:0]   w_pattern;
    logic                    w_last;
    logic                    w_mismatch;
    logic                    w_load_start;
    logic                    w_issue_wr;
    logic                    w_issue_rd;
    logic                    w_wr_ack;
    logic                    w_rd_ack;
    logic                    w_timeout;
    logic                    w_abort;
    logic                    w_waiting;

    assign w_last     = (r_cur_addr == c_end_addr);
    assign w_pattern  = DATA_WIDTH'(w_pattern16);
    assign w_mismatch = (rdata_i != w_pattern);
    assign w_waiting  = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);

`ifdef MEMTEST_LFSR_PATTERN_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_pattern16 = r_lfsr;

    // LFSR reloads at the start of each phase and steps once per acked word
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (w_load_start || (w_wr_ack && w_last)) begin
            r_lfsr <= SEED;
        end else if (w_wr_ack || w_rd_ack) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    // Address-derived pattern: the read phase recomputes it from cur_addr
    assign w_pattern16 = r_cur_addr[15:0] ^ SEED;
`endif

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and single-cycle datapath strobes; abort outranks ack/timeout
    always_comb begin
        w_state_next = r_state;
        w_load_start = 1'b0;
        w_issue_wr   = 1'b0;
        w_issue_rd   = 1'b0;
        w_wr_ack     = 1'b0;
        w_rd_ack     = 1'b0;
        w_timeout    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (!abort_i && start_i) begin
                    w_load_start = 1'b1;
                    w_state_next = S_WR_REQ;
                end
            end
            S_WR_REQ, S_RD_REQ: begin
                if (abort_i) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (!busy_i) begin
                    w_issue_wr   = (r_state == S_WR_REQ);
                    w_issue_rd   = (r_state == S_RD_REQ);
                    w_state_next = (r_state == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
                end
            end
            S_WR_WAIT, S_RD_WAIT: begin
                if (abort_i) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (ack_i) begin
                    if (r_state == S_WR_WAIT) begin
                        w_wr_ack     = 1'b1;
                        w_state_next = w_last ? S_RD_REQ : S_WR_REQ;
                    end else begin
                        w_rd_ack     = 1'b1;
                        w_state_next = w_last ? S_DONE : S_RD_REQ;
                    end
                end else if (r_wait_cnt == c_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request registers, address walk, wait counter and result accumulation
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_o           <= '0;
            wdata_o          <= '0;
            we_o             <= 1'b0;
            re_o             <= 1'b0;
            running_o        <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
            first_err_data_o <= '0;
            r_cur_addr       <= c_start_addr;
            r_wait_cnt       <= '0;
        end else begin
            we_o <= w_issue_wr;
            re_o <= w_issue_rd;

            if (w_load_start) begin
                err_count_o      <= '0;
                first_err_addr_o <= '0;
                first_err_data_o <= '0;
                timeout_o        <= 1'b0;
                pass_o           <= 1'b0;
                done_o           <= 1'b0;
                running_o        <= 1'b1;
                r_cur_addr       <= c_start_addr;
            end

            if (w_issue_wr || w_issue_rd) begin
                addr_o     <= r_cur_addr;
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + c_cnt_one;
            end

            if (w_issue_wr) begin
                wdata_o <= w_pattern;
            end

            if (w_wr_ack) begin
                r_cur_addr <= w_last ? c_start_addr : (r_cur_addr + c_addr_one);
            end

            if (w_rd_ack) begin
                if (w_mismatch) begin
                    if (err_count_o != 16'hFFFF) begin
                        err_count_o <= err_count_o + 16'd1;
                    end
                    if (err_count_o == 16'd0) begin
                        first_err_addr_o <= r_cur_addr;
                        first_err_data_o <= rdata_i;
                    end
                end
                if (w_last) begin
                    running_o <= 1'b0;
                    done_o    <= 1'b1;
                    pass_o    <= !w_mismatch && (err_count_o == 16'd0) && !timeout_o;
                end else begin
                    r_cur_addr <= r_cur_addr + c_addr_one;
                end
            end

            if (w_timeout) begin
                timeout_o <= 1'b1;
                running_o <= 1'b0;
                done_o    <= 1'b1;
                pass_o    <= 1'b0;
            end

            if (w_abort) begin
                running_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_mem_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_mem_tester
// Brief    : Scoreboard bench for sdram_mem_tester. A memory model acks each
//            request 3 cycles later; expected requests and results are queued
//            by the stimulus and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_mem_tester;

    localparam int AW  = 25;
    localparam int DW  = 16;
    localparam int TMO = 64;

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          ack_i   = 1'b0;
    logic          busy_i  = 1'b0;
    logic [DW-1:0] rdata_i = '0;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          we_o;
    logic          re_o;
    logic          running_o;
    logic          done_o;
    logic          pass_o;
    logic          timeout_o;
    logic [15:0]   err_count_o;
    logic [AW-1:0] first_err_addr_o;
    logic [DW-1:0] first_err_data_o;

    sdram_mem_tester #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .START_ADDR     (0),
        .END_ADDR       (15),
        .TIMEOUT_CYCLES (TMO),
        .SEED           (16'hA5A5)
    ) dut (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .addr_o           (addr_o),
        .wdata_o          (wdata_o),
        .we_o             (we_o),
        .re_o             (re_o),
        .rdata_i          (rdata_i),
        .ack_i            (ack_i),
        .busy_i           (busy_i),
        .running_o        (running_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .timeout_o        (timeout_o),
        .err_count_o      (err_count_o),
        .first_err_addr_o (first_err_addr_o),
        .first_err_data_o (first_err_data_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        logic [15:0]   err;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fdata;
        bit            pass;
        bit            tmo;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // memory-model configuration, written only by the stimulus process
    int   cfg_corrupt = -1;
    int   cfg_noack   = -1;
    bit   cfg_busy    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef MEMTEST_LFSR_PATTERN_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
`endif

    // expected pattern for the i-th word of a phase starting at address 0
    function automatic logic [15:0] exp_pat(input int idx);
`ifdef MEMTEST_LFSR_PATTERN_EN
        logic [15:0] s;
        s = 16'hA5A5;
        for (int k = 0; k < idx; k++) s = lfsr_step(s);
        return s;
`else
        return 16'(idx) ^ 16'hA5A5;
`endif
    endfunction

    task automatic push_reqs(input int last_wr, input int last_rd);
        req_t r;
        for (int a = 0; a <= last_wr; a++) begin
            r.is_wr = 1'b1; r.addr = AW'(a); r.data = exp_pat(a);
            exp_req.push_back(r);
        end
        for (int a = 0; a <= last_rd; a++) begin
            r.is_wr = 1'b0; r.addr = AW'(a); r.data = '0;
            exp_req.push_back(r);
        end
    endtask

    task automatic push_res(input logic [15:0] err, input int faddr, input logic [15:0] fdata,
                            input bit pass, input bit tmo);
        res_t e;
        e.err = err; e.faddr = AW'(faddr); e.fdata = fdata; e.pass = pass; e.tmo = tmo;
        exp_res.push_back(e);
    endtask

    // ---------------- memory model: ack 3 cycles after each request ----------
    logic [DW-1:0] mem [0:15];
    int            m_cnt  = 0;
    bit            m_pend = 1'b0;
    bit            m_wr   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            m_busy = 0;

    initial begin
        forever begin
            @(posedge sys_clk); #2;
            ack_i = 1'b0;
            if (m_busy > 0) m_busy--;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pend = 1'b0;
                    ack_i  = 1'b1;
                    if (m_wr) mem[m_addr[3:0]] = m_data;
                    else rdata_i = (cfg_corrupt == int'(m_addr)) ? '0 : mem[m_addr[3:0]];
                    if (cfg_busy && (m_addr == 6 || (m_wr && m_addr == 15))) m_busy = 20;
                end
            end
            if (cfg_busy && start_i) m_busy = 20;
            if (we_o || re_o) begin
                m_wr = we_o; m_addr = addr_o; m_data = wdata_o;
                if (!(re_o && cfg_noack == int'(addr_o))) begin
                    m_pend = 1'b1;
                    m_cnt  = 3;
                end
            end
            busy_i = (m_busy != 0);
        end
    end

    // ---------------- monitor: pops the scoreboard on DUT activity ----------
    bit            busy_prev = 1'b0;
    bit            done_prev = 1'b0;
    bit            have_last = 1'b0;
    bit            last_wr   = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    int            cyc       = 0;
    int            req_cyc   = 0;
    req_t          mr;
    res_t          me;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (rst_n) begin
                if (we_o || re_o) begin
                    chk("req_after_busy", 32'(busy_prev), 32'd0);
                    chk("req_single_strobe", 32'(we_o && re_o), 32'd0);
                    chk("req_expected", 32'(exp_req.size() != 0), 32'd1);
                    if (exp_req.size() != 0) begin
                        mr = exp_req.pop_front();
                        chk("req_kind_we", 32'(we_o), 32'(mr.is_wr));
                        chk("req_addr", 32'(addr_o), 32'(mr.addr));
                        if (mr.is_wr) chk("req_wdata", 32'(wdata_o), 32'(mr.data));
                    end
                    have_last = 1'b1; last_wr = we_o;
                    last_addr = addr_o; last_data = wdata_o; req_cyc = cyc;
                end
                if (ack_i && have_last) begin
                    chk("hold_addr", 32'(addr_o), 32'(last_addr));
                    if (last_wr) chk("hold_wdata", 32'(wdata_o), 32'(last_data));
                end
                if (done_o && !done_prev) begin
                    chk("done_expected", 32'(exp_res.size() != 0), 32'd1);
                    if (exp_res.size() != 0) begin
                        me = exp_res.pop_front();
                        chk("res_err_count", 32'(err_count_o), 32'(me.err));
                        chk("res_first_addr", 32'(first_err_addr_o), 32'(me.faddr));
                        chk("res_first_data", 32'(first_err_data_o), 32'(me.fdata));
                        chk("res_pass", 32'(pass_o), 32'(me.pass));
                        chk("res_timeout", 32'(timeout_o), 32'(me.tmo));
                        chk("res_running", 32'(running_o), 32'd0);
                        if (me.tmo) chk("timeout_latency", 32'(cyc - req_cyc), 32'(TMO));
                    end
                end
            end
            busy_prev = busy_i;
            done_prev = done_o;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(posedge sys_clk); #1 start_i = 1'b1;
        @(posedge sys_clk); #1 start_i = 1'b0;
        @(negedge sys_clk);
        chk("running_after_start", 32'(running_o), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_o; i++) @(negedge sys_clk);
        chk("done_within_budget", 32'(done_o), 32'd1);
        repeat (10) @(negedge sys_clk);
        chk("all_requests_seen", 32'(exp_req.size()), 32'd0);
        chk("all_results_seen", 32'(exp_res.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_re", 32'(re_o), 32'd0);
        chk("rst_addr", 32'(addr_o), 32'd0);
        chk("rst_wdata", 32'(wdata_o), 32'd0);
        chk("rst_running", 32'(running_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_pass", 32'(pass_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_err_count", 32'(err_count_o), 32'd0);
        chk("rst_first_addr", 32'(first_err_addr_o), 32'd0);
        chk("rst_first_data", 32'(first_err_data_o), 32'd0);
        @(posedge sys_clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);

        // clean pass over 0..15
        push_reqs(15, 15);
        push_res(16'd0, 0, 16'h0000, 1'b1, 1'b0);
        pulse_start();
        wait_done(3000);

        // address 5 reads back as zero
        cfg_corrupt = 5;
        push_reqs(15, 15);
        push_res(16'd1, 5, 16'h0000, 1'b0, 1'b0);
        pulse_start();
        wait_done(3000);
        cfg_corrupt = -1;

        // busy backpressure ahead of addresses 0 and 7
        cfg_busy = 1'b1;
        push_reqs(15, 15);
        push_res(16'd0, 0, 16'h0000, 1'b1, 1'b0);
        pulse_start();
        wait_done(3000);
        cfg_busy = 1'b0;

        // read at address 3 is never acknowledged
        cfg_noack = 3;
        push_reqs(15, 3);
        push_res(16'd0, 0, 16'h0000, 1'b0, 1'b1);
        pulse_start();
        wait_done(3000);
        repeat (100) @(negedge sys_clk);
        chk("no_req_after_timeout", 32'(exp_req.size()), 32'd0);
        cfg_noack = -1;

        // abort and start together: abort wins, results stay held
        @(posedge sys_clk); #1 start_i = 1'b1; abort_i = 1'b1;
        @(posedge sys_clk); #1 start_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("abort_start_running", 32'(running_o), 32'd0);
        chk("abort_start_done_held", 32'(done_o), 32'd1);
        chk("abort_start_timeout_held", 32'(timeout_o), 32'd1);

        // abort during the write of address 8
        push_reqs(8, -1);
        pulse_start();
        for (int i = 0; i < 500 && !(we_o && addr_o == 8); i++) @(negedge sys_clk);
        chk("saw_write_addr8", 32'(we_o && addr_o == 8), 32'd1);
        @(posedge sys_clk); #1 abort_i = 1'b1;
        @(posedge sys_clk); #1 abort_i = 1'b0;
        @(negedge sys_clk);
        chk("abort_running", 32'(running_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        repeat (30) @(negedge sys_clk);
        chk("abort_no_more_req", 32'(exp_req.size()), 32'd0);
        chk("abort_still_idle", 32'(running_o | done_o), 32'd0);

        // full rerun after abort
        push_reqs(15, 15);
        push_res(16'd0, 0, 16'h0000, 1'b1, 1'b0);
        pulse_start();
        wait_done(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
